// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - six-digit multiplexed 7-segment scanner for the digital clock
//
// Scans six BCD digits {H1,H0,M1,M0,S1,S0} onto a common-anode display.
// The digits are captured once per frame, so one frame never shows a mix of
// values from before and after a counter carry. Supports per-digit blinking
// for time-set mode and blanking of a leading zero in the hours tens.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          synchronous active-high reset
//   digits       BCD nibbles, [3:0] = seconds units ... [23:20] = hours tens
//   blink_mask   bit i set -> digit i blinks (bit 0 = seconds units)
//   lz_blank     1 -> blank the hours tens digit when it is 0
//   an           anodes, active-low, an[i] drives digit i
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low (lit after hours and minutes)
//   frame_start  one-cycle pulse on the first slot of each frame
//
// Parameters:
//   SCAN_DIV      clk cycles per digit slot (>= DEAD+1)
//   DEAD          blank cycles at the start of each slot (anti-ghosting)
//   BLINK_FRAMES  frames per blink half-period (>= 1)

module bcd_display_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEAD         = 1,
    parameter int BLINK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] digits,
    input  logic [5:0]  blink_mask,
    input  logic        lz_blank,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    // Counter widths; keep at least one bit so degenerate parameter values
    // still produce legal vectors.
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW:0]   DEAD_CNT   = (SW + 1)'(DEAD);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    INDEX_LAST = 3'd5;

    localparam logic [5:0] AN_OFF  = 6'b111111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [SW-1:0] slot;
    logic [2:0]    index;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [23:0]   snapshot;

    logic [SW-1:0] slot_n;
    logic [2:0]    index_n;
    logic [FW-1:0] frame_cnt_n;
    logic          blink_phase_n;
    logic [23:0]   snapshot_n;

    logic          slot_wrap;
    logic          boundary;

    // Output candidates, computed from the next scan state so that the
    // registered outputs describe the scan position they are shown in.
    logic [3:0]    nibble_n;
    logic          dead_n;
    logic          blinked_n;
    logic          lz_off_n;
    logic          lit_n;
    logic [5:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic          frame_start_n;

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash so a corrupted
    // counter stage is visible instead of silently wrong.
    function automatic logic [6:0] decode_bcd(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        slot_n        = slot;
        index_n       = index;
        frame_cnt_n   = frame_cnt;
        blink_phase_n = blink_phase;
        snapshot_n    = snapshot;

        slot_wrap = (slot == SLOT_LAST);
        boundary  = slot_wrap && (index == INDEX_LAST);

        if (slot_wrap) begin
            slot_n  = '0;
            index_n = (index == INDEX_LAST) ? 3'd0 : index + 3'd1;
        end else begin
            slot_n  = slot + 1'b1;
        end

        // Frame boundary: freeze a fresh copy of the digits and advance the
        // blink timebase.
        if (boundary) begin
            snapshot_n = digits;
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt_n   = '0;
                blink_phase_n = ~blink_phase;
            end else begin
                frame_cnt_n   = frame_cnt + 1'b1;
            end
        end

        nibble_n  = snapshot_n[{index_n, 2'b00} +: 4];
        dead_n    = ({1'b0, slot_n} < DEAD_CNT);
        blinked_n = blink_phase_n && blink_mask[index_n];
        lz_off_n  = lz_blank && (index_n == INDEX_LAST) && (nibble_n == 4'd0);
        lit_n     = !dead_n && !blinked_n && !lz_off_n;

        an_n  = AN_OFF;
        seg_n = SEG_OFF;
        dp_n  = 1'b1;
        if (lit_n) begin
            an_n  = ~(6'b000001 << index_n);
            seg_n = decode_bcd(nibble_n);
            // Separator dots sit on the units digits of hours and minutes.
            dp_n  = !((index_n == 3'd2) || (index_n == 3'd4));
        end

        frame_start_n = (index_n == 3'd0) && (slot_n == '0);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // Reset parks the scan on the last slot of the last digit, so the first
    // edge out of reset is a frame boundary: snapshot load plus frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot        <= SLOT_LAST;
            index       <= INDEX_LAST;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            snapshot    <= '0;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            slot        <= slot_n;
            index       <= index_n;
            frame_cnt   <= frame_cnt_n;
            blink_phase <= blink_phase_n;
            snapshot    <= snapshot_n;
            an          <= an_n;
            seg         <= seg_n;
            dp          <= dp_n;
            frame_start <= frame_start_n;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - self-checking bench for bcd_display_scanner

module tb_bcd_display_scanner;

    localparam int SD    = 4;
    localparam int DEADC = 1;
    localparam int BF    = 2;
    localparam int FRAME = 6 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] digits = 24'h0;
    logic [5:0]  blink_mask = 6'h0;
    logic        lz_blank = 1'b0;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_display_scanner #(
        .SCAN_DIV(SD),
        .DEAD(DEADC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .digits(digits),
        .blink_mask(blink_mask),
        .lz_blank(lz_blank),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset release, with frame contents and
    // blink phase derived arithmetically from that time.
    int          t = 0;
    bit          mrst = 1'b1;
    bit          mvalid = 1'b0;
    logic [23:0] msnap = 24'h0;
    logic [5:0]  mmask = 6'h0;
    logic        mlz = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mrst   = 1'b1;
            mvalid = 1'b1;
        end else begin
            if (mrst) t = 0;
            else t = t + 1;
            mrst = 1'b0;
            if (t % FRAME == 0) msnap = digits;
        end
        mmask = blink_mask;
        mlz   = lz_blank;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            logic [5:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp;
            logic       e_fs;
            e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
            if (!mrst) begin
                int idx, slot, frame, phase;
                logic [3:0] nib;
                logic lit;
                idx   = (t / SD) % 6;
                slot  = t % SD;
                frame = t / FRAME;
                phase = ((frame + 1) / BF) % 2;
                nib   = msnap[4*idx +: 4];
                lit   = (slot >= DEADC) && !(phase == 1 && mmask[idx])
                        && !(mlz && idx == 5 && nib == 4'd0);
                if (lit) begin
                    e_an  = 6'h3F & ~(6'(1) << idx);
                    e_seg = seg_tab[nib];
                    e_dp  = !(idx == 2 || idx == 4);
                end
                e_fs = (t % FRAME == 0);
            end
            check("model an", 32'(an), 32'(e_an));
            check("model seg", 32'(seg), 32'(e_seg));
            check("model dp", 32'(dp), 32'(e_dp));
            check("model frame_start", 32'(frame_start), 32'(e_fs));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 4 * FRAME && !found; k++) begin
            @(negedge clk);
            if (frame_start) found = 1'b1;
        end
        check("frame_start timeout", 32'(found), 32'd1);
    endtask

    initial begin
        int  cnt;
        bit  hl, ml;

        // Reset and first frame
        rst = 1'b1; digits = 24'h235959;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("c1 frame_start", 32'(frame_start), 32'd1);
        check("c1 an", 32'(an), 32'h3F);
        tick(1);
        check("c2 an", 32'(an), 32'h3E);
        check("c2 seg", 32'(seg), 32'(7'b0010000));
        tick(4);
        check("c6 an", 32'(an), 32'h3D);
        check("c6 seg", 32'(seg), 32'(7'b0010010));
        tick(3);
        check("c9 dead an", 32'(an), 32'h3F);
        check("c9 dead dp", 32'(dp), 32'd1);
        tick(1);
        check("c10 an", 32'(an), 32'h3B);
        check("c10 dp", 32'(dp), 32'd0);
        tick(2 * FRAME);

        // Mid-frame digit change is held off until the next frame
        digits = 24'h000009;
        wait_frame();
        digits = 24'h000010;
        tick(1);
        check("hold old digit seg", 32'(seg), 32'(7'b0010000));
        wait_frame();
        tick(1);
        check("new digit0 seg", 32'(seg), 32'(7'b1000000));
        tick(4);
        check("new digit1 an", 32'(an), 32'h3D);
        check("new digit1 seg", 32'(seg), 32'(7'b1111001));

        // Non-BCD nibble shows a dash
        digits = 24'h00000A;
        wait_frame();
        tick(1);
        check("dash seg", 32'(seg), 32'(7'b0111111));
        tick(4);
        check("dash neighbour seg", 32'(seg), 32'(7'b1000000));

        // Leading-zero blanking
        lz_blank = 1'b1;
        digits = 24'h012345;
        wait_frame();
        cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (!an[5]) cnt++;
            tick(1);
        end
        check("lz blank an5 low count", 32'(cnt), 32'd0);
        digits = 24'h112345;
        wait_frame();
        tick(21);
        check("lz nonzero an", 32'(an), 32'h1F);
        check("lz nonzero seg", 32'(seg), 32'(7'b1111001));
        tick(2);
        check("lz nonzero slot3 an", 32'(an), 32'h1F);
        lz_blank = 1'b0;

        // Blinking hours from a clean reset
        blink_mask = 6'b110000;
        digits = 24'h123456;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int f = 0; f < 6; f++) begin
            hl = 1'b0; ml = 1'b0;
            repeat (FRAME) begin
                tick(1);
                if (!an[5] || !an[4]) hl = 1'b1;
                if (!an[2]) ml = 1'b1;
            end
            check($sformatf("blink hours frame %0d", f), 32'(hl),
                  32'((f == 0 || f == 3 || f == 4) ? 1 : 0));
            check($sformatf("blink minutes frame %0d", f), 32'(ml), 32'd1);
        end
        blink_mask = 6'h0;

        // Reset in the middle of a frame
        wait_frame();
        tick(13);
        check("pre-reset an", 32'(an), 32'h37);
        rst = 1'b1;
        tick(1);
        check("mid reset an", 32'(an), 32'h3F);
        check("mid reset seg", 32'(seg), 32'h7F);
        check("mid reset dp", 32'(dp), 32'd1);
        check("mid reset frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;
        tick(1);
        check("restart frame_start", 32'(frame_start), 32'd1);
        check("restart an", 32'(an), 32'h3F);
        tick(1);
        check("restart index0 an", 32'(an), 32'h3E);
        tick(FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
